// File: rtl/ula_pkg.sv
// ula_pkg: shared types and widths for the ULA divider datapath.
//   div_state_t  : divider FSM states
//   ULA_DVD_W    : dividend / quotient width
//   ULA_DVS_W    : divisor / remainder width
package ula_pkg;

    localparam int ULA_DVD_W = 16;
    localparam int ULA_DVS_W = 8;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIXUP,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/ula_divider_if.sv
// ula_divider_if: start/busy/done handshake and operand/result bus between
// the ULA control FSM (master) and the divider (slave).
//   start, dividend, divisor              : master -> slave
//   busy, done, quotient, remainder, flags : slave -> master
interface ula_divider_if;
    import ula_pkg::*;

    logic                 start;
    logic [ULA_DVD_W-1:0] dividend;
    logic [ULA_DVS_W-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [ULA_DVD_W-1:0] quotient;
    logic [ULA_DVS_W-1:0] remainder;
    logic                 sign_flag;
    logic                 zero_flag;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder,
        input  sign_flag, zero_flag, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder,
        output sign_flag, zero_flag, div_by_zero, overflow
    );

endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit full adder, the cell of the ULA adder datapath.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_eight_bits.sv
// rca_eight_bits: 8-bit ripple-carry adder built from full_adder cells.
//   a, b : 8-bit addends
//   cin  : carry into bit 0
//   sum  : 8-bit sum
//   cout : carry out of bit 7
module rca_eight_bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[8];

    for (genvar i = 0; i < 8; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/ula_div_step.sv
// ula_div_step: one radix-2 restoring division step (combinational).
//   rem_in  : current partial remainder (always below the divisor magnitude)
//   bit_in  : next dividend bit shifted into the remainder
//   dvs_mag : 9-bit divisor magnitude (1..128)
//   rem_out : partial remainder after the conditional subtract
//   q_bit   : quotient bit, 1 when the subtract was taken
module ula_div_step (
    input  logic [7:0] rem_in,
    input  logic       bit_in,
    input  logic [8:0] dvs_mag,
    output logic [7:0] rem_out,
    output logic       q_bit
);

    logic [8:0] shifted;
    logic [8:0] dvs_inv;
    logic [7:0] diff_lo;
    logic       carry_lo;
    logic       diff_msb_unused;

    assign shifted = {rem_in, bit_in};
    assign dvs_inv = ~dvs_mag;

    // shifted - dvs_mag as shifted + ~dvs_mag + 1; the final carry is the
    // "no borrow" indication, i.e. shifted >= dvs_mag.
    rca_eight_bits u_sub_lo (
        .a    (shifted[7:0]),
        .b    (dvs_inv[7:0]),
        .cin  (1'b1),
        .sum  (diff_lo),
        .cout (carry_lo)
    );

    full_adder u_sub_hi (
        .a    (shifted[8]),
        .b    (dvs_inv[8]),
        .cin  (carry_lo),
        .sum  (diff_msb_unused),
        .cout (q_bit)
    );

    // The kept remainder is below the divisor magnitude (<= 128), so only
    // the low byte of either path ever carries information.
    assign rem_out = q_bit ? diff_lo : shifted[7:0];

endmodule

// File: rtl/ula_divider.sv
// ula_divider: sequential signed divider, 16-bit dividend / 8-bit divisor.
// Restoring shift-subtract on magnitudes, one quotient bit per clock,
// followed by a sign fix-up cycle and a one-cycle done pulse.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of ula_divider_if (start/operands in,
//           busy/done/quotient/remainder/flags out)
module ula_divider
    import ula_pkg::*;
#(
    parameter int DIVIDEND_W = ULA_DVD_W,
    parameter int DIVISOR_W  = ULA_DVS_W
) (
    input logic          clk,
    input logic          reset,
    ula_divider_if.slave bus
);

    div_state_t state_q, state_d;

    logic [3:0]            count_q, count_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W-1:0]  p_q, p_d;
    logic [DIVISOR_W:0]    dvs_mag_q, dvs_mag_d;
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dvs_neg_q, dvs_neg_d;
    logic                  dvz_q, dvz_d;

    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  sign_q, sign_d;
    logic                  zero_q, zero_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    // Shared negators (invert + ripple increment). In IDLE they produce the
    // operand magnitudes; in FIXUP they produce the signed results.
    logic [DIVIDEND_W-1:0] neg16_src, neg16_inv, neg16;
    logic                  neg16_c8;
    logic                  neg16_carry_unused;
    logic [DIVISOR_W-1:0]  neg8_src, neg8;
    logic                  neg8_carry_unused;

    assign neg16_src = (state_q == DIV_IDLE) ? bus.dividend : q_q;
    assign neg16_inv = ~neg16_src;
    assign neg8_src  = (state_q == DIV_IDLE) ? bus.divisor : p_q;

    rca_eight_bits u_neg16_lo (
        .a    (neg16_inv[7:0]),
        .b    (8'h00),
        .cin  (1'b1),
        .sum  (neg16[7:0]),
        .cout (neg16_c8)
    );

    rca_eight_bits u_neg16_hi (
        .a    (neg16_inv[15:8]),
        .b    (8'h00),
        .cin  (neg16_c8),
        .sum  (neg16[15:8]),
        .cout (neg16_carry_unused)
    );

    rca_eight_bits u_neg8 (
        .a    (~neg8_src),
        .b    (8'h00),
        .cin  (1'b1),
        .sum  (neg8),
        .cout (neg8_carry_unused)
    );

    logic [DIVISOR_W-1:0] step_rem;
    logic                 step_bit;

    ula_div_step u_step (
        .rem_in  (p_q),
        .bit_in  (q_q[DIVIDEND_W-1]),
        .dvs_mag (dvs_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Next-state and datapath control. Q holds the dividend magnitude at
    // accept and shifts quotient bits in from the bottom as dividend bits
    // leave from the top.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        p_d         = p_q;
        dvs_mag_d   = dvs_mag_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        dvz_d       = dvz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            DIV_IDLE: begin
                if (bus.start) begin
                    q_d       = bus.dividend[DIVIDEND_W-1] ? neg16 : bus.dividend;
                    dvs_mag_d = {1'b0, (bus.divisor[DIVISOR_W-1] ? neg8 : bus.divisor)};
                    dvd_neg_d = bus.dividend[DIVIDEND_W-1];
                    dvs_neg_d = bus.divisor[DIVISOR_W-1];
                    dvz_d     = (bus.divisor == '0);
                    p_d       = '0;
                    count_d   = '0;
                    sign_d    = 1'b0;
                    zero_d    = 1'b0;
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = (bus.divisor == '0) ? DIV_FIXUP : DIV_RUN;
                end
            end

            DIV_RUN: begin
                q_d     = {q_q[DIVIDEND_W-2:0], step_bit};
                p_d     = step_rem;
                count_d = count_q + 4'd1;
                if (count_q == 4'(DIVIDEND_W - 1)) begin
                    state_d = DIV_FIXUP;
                end
            end

            DIV_FIXUP: begin
                if (dvz_q) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    sign_d      = 1'b0;
                    zero_d      = 1'b1;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else begin
                    quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? neg16 : q_q;
                    remainder_d = dvd_neg_q ? neg8 : p_q;
                    sign_d      = quotient_d[DIVIDEND_W-1];
                    zero_d      = (quotient_d == '0);
                    // Only -32768 / -1 yields a magnitude of 32768 with a
                    // divisor magnitude of 1 and both operands negative.
                    ovf_d       = dvd_neg_q && dvs_neg_q
                                  && (q_q == {1'b1, {(DIVIDEND_W-1){1'b0}}})
                                  && (dvs_mag_q == (DIVISOR_W+1)'(1));
                end
                state_d = DIV_DONE;
            end

            DIV_DONE: begin
                state_d = DIV_IDLE;
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            q_q         <= '0;
            p_q         <= '0;
            dvs_mag_q   <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dvz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            p_q         <= p_d;
            dvs_mag_q   <= dvs_mag_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            dvz_q       <= dvz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.busy        = (state_q == DIV_RUN) || (state_q == DIV_FIXUP);
    assign bus.done        = (state_q == DIV_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.sign_flag   = sign_q;
    assign bus.zero_flag   = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_ula_divider.sv
// tb_ula_divider: directed-vector scoreboard bench for ula_divider.
// Stimulus pushes hand-computed expected results; a negedge monitor pops
// and compares whenever done is presented.
module tb_ula_divider;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        string       name;
        logic [15:0] q;
        logic [7:0]  r;
        logic        s;
        logic        z;
        logic        dbz;
        logic        ovf;
        int          done_cycle;
    } exp_t;

    exp_t sb_q[$];

    ula_divider_if bus ();

    ula_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cycle);
            end else begin
                e = sb_q.pop_front();
                checkOutput({e.name, " quotient"},    32'(bus.quotient),    32'(e.q));
                checkOutput({e.name, " remainder"},   32'(bus.remainder),   32'(e.r));
                checkOutput({e.name, " sign_flag"},   32'(bus.sign_flag),   32'(e.s));
                checkOutput({e.name, " zero_flag"},   32'(bus.zero_flag),   32'(e.z));
                checkOutput({e.name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
                checkOutput({e.name, " overflow"},    32'(bus.overflow),    32'(e.ovf));
                checkOutput({e.name, " busy_at_done"}, 32'(bus.busy),       32'(0));
                checkOutput({e.name, " done_cycle"},  32'(cycle),           32'(e.done_cycle));
            end
        end
    end

    task automatic waitIdle();
        int w = 0;
        while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_idle: got busy=%0b done=%0b expected idle within 60 cycles", bus.busy, bus.done);
        end
    endtask

    task automatic waitDrain();
        int w = 0;
        while ((sb_q.size() != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Issue one operation; latency counts the accept edge as edge 1.
    task automatic applyStimulus(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                                 input logic [15:0] eq, input logic [7:0] er,
                                 input logic es, input logic ez, input logic edz, input logic eov);
        exp_t e;
        int   lat;
        waitIdle();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = (dvs == 8'h00) ? 2 : 18;
        e.name = name; e.q = eq; e.r = er; e.s = es; e.z = ez; e.dbz = edz; e.ovf = eov;
        e.done_cycle = cycle + lat - 1;
        sb_q.push_back(e);
        checkOutput({name, " busy_after_accept"}, 32'(bus.busy), 32'(1));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"},        32'(bus.busy),        32'(0));
        checkOutput({tag, " done"},        32'(bus.done),        32'(0));
        checkOutput({tag, " quotient"},    32'(bus.quotient),    32'(0));
        checkOutput({tag, " remainder"},   32'(bus.remainder),   32'(0));
        checkOutput({tag, " sign_flag"},   32'(bus.sign_flag),   32'(0));
        checkOutput({tag, " zero_flag"},   32'(bus.zero_flag),   32'(0));
        checkOutput({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(0));
        checkOutput({tag, " overflow"},    32'(bus.overflow),    32'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 16'h0000;
        bus.divisor  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset_state");
        reset = 1'b0;

        applyStimulus("pos_by_pos",  16'd100,  8'd7,   16'd14,   8'd2,   1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("neg_by_pos",  16'hFF9C, 8'd7,   16'hFFF2, 8'hFE,  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("pos_by_neg",  16'd1000, 8'hFD,  16'hFEB3, 8'h01,  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("div_zero",    16'h1234, 8'h00,  16'h0000, 8'h00,  1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("neg_small",   16'hFFF9, 8'd2,   16'hFFFD, 8'hFF,  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("by_min_dvs",  16'h0100, 8'h80,  16'hFFFE, 8'h00,  1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("min_by_min",  16'h8000, 8'h80,  16'h0100, 8'h00,  1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("rem_only",    16'h007F, 8'h80,  16'h0000, 8'h7F,  1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("overflow",    16'h8000, 8'hFF,  16'h8000, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1);
        waitDrain();

        // Reset in the middle of RUN discards the operation entirely.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_run busy", 32'(bus.busy), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("after_reset");
        reset = 1'b0;

        // A start pulsed while busy must be ignored.
        applyStimulus("zero_by_five", 16'd0, 8'd5, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        waitDrain();
        repeat (25) @(negedge clk);
        checkOutput("no_extra_ops busy", 32'(bus.busy), 32'(0));
        checkOutput("queue_empty", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
